// File: rtl/frame_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding, counter widths
// and the saturating-increment helper used by the statistics counters.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IMU_REQ   = 3'd1,
    IMU_WAIT  = 3'd2,
    PHYS_REQ  = 3'd3,
    PHYS_WAIT = 3'd4,
    LED_REQ   = 3'd5,
    LED_WAIT  = 3'd6
  } state_e;

  localparam int SAT_W       = 8;
  localparam int FRAME_CNT_W = 16;
  localparam logic [SAT_W-1:0] SAT_MAX = 8'hFF;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    logic [SAT_W-1:0] r;
    if (v == SAT_MAX) r = v;
    else              r = v + SAT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick is high on the last count of each period.
module frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (cnt_q == LAST) cnt_d = '0;
    else               cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: IMU read -> physics step -> LED refresh, each stage with a
// bounded wait, plus overrun/timeout statistics and a sticky fault flag.
module frame_scheduler
  import frame_pkg::*;
#(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DATA_W         = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imu_start,
  input  logic                   imu_done,
  input  logic [DATA_W-1:0]      imu_data,
  output logic                   phys_start,
  input  logic                   phys_done,
  output logic [DATA_W-1:0]      phys_data,
  output logic                   led_start,
  input  logic                   led_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [SAT_W-1:0]       timeout_count,
  output logic [SAT_W-1:0]       overrun_count,
  output logic                   fault
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   pending_q, pending_d;
  logic [DATA_W-1:0]      phys_data_q, phys_data_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [SAT_W-1:0]       tmo_q, tmo_d;
  logic [SAT_W-1:0]       ovr_q, ovr_d;
  logic                   fault_q, fault_d;
  logic                   imu_start_q, imu_start_d;
  logic                   phys_start_q, phys_start_d;
  logic                   led_start_q, led_start_d;
  logic                   busy_q, busy_d;

  logic tick_s;
  logic in_wait_s;
  logic done_s;
  logic timeout_s;
  logic stage_end_s;
  logic tmo_hit_s;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Done is only honoured in the matching wait state; done beats a same-cycle timeout.
  assign in_wait_s   = (state_q == IMU_WAIT) || (state_q == PHYS_WAIT) || (state_q == LED_WAIT);
  assign done_s      = ((state_q == IMU_WAIT)  && imu_done)  ||
                       ((state_q == PHYS_WAIT) && phys_done) ||
                       ((state_q == LED_WAIT)  && led_done);
  assign timeout_s   = in_wait_s && (wait_q == WAIT_LAST);
  assign stage_end_s = in_wait_s && (done_s || timeout_s);
  assign tmo_hit_s   = timeout_s && !done_s;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tick_s || pending_q) state_d = IMU_REQ;
        else                     state_d = IDLE;
      end
      IMU_REQ:  state_d = IMU_WAIT;
      IMU_WAIT: begin
        if (stage_end_s) state_d = PHYS_REQ;
        else             state_d = IMU_WAIT;
      end
      PHYS_REQ: state_d = PHYS_WAIT;
      PHYS_WAIT: begin
        if (stage_end_s) state_d = LED_REQ;
        else             state_d = PHYS_WAIT;
      end
      LED_REQ:  state_d = LED_WAIT;
      LED_WAIT: begin
        if (stage_end_s) state_d = IDLE;
        else             state_d = LED_WAIT;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    imu_start_d  = (state_d == IMU_REQ);
    phys_start_d = (state_d == PHYS_REQ);
    led_start_d  = (state_d == LED_REQ);
    busy_d       = (state_d != IDLE);
  end

  always_comb begin
    if (in_wait_s) wait_d = wait_q + WAIT_W'(1);
    else           wait_d = '0;

    if ((state_q == IMU_WAIT) && imu_done) phys_data_d = imu_data;
    else                                   phys_data_d = phys_data_q;

    if ((state_q == LED_WAIT) && stage_end_s) frame_d = frame_q + FRAME_CNT_W'(1);
    else                                      frame_d = frame_q;

    if (tmo_hit_s) begin
      tmo_d   = sat_inc(tmo_q);
      fault_d = 1'b1;
    end else begin
      tmo_d   = tmo_q;
      fault_d = fault_q;
    end

    if (tick_s && (state_q != IDLE)) ovr_d = sat_inc(ovr_q);
    else                             ovr_d = ovr_q;

    // Leaving IDLE consumes the pending tick, but a tick on that very cycle re-arms it.
    if (tick_s && ((state_q != IDLE) || pending_q)) pending_d = 1'b1;
    else if (state_q == IDLE)                       pending_d = 1'b0;
    else                                            pending_d = pending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q       <= '0;
      pending_q    <= 1'b0;
      phys_data_q  <= '0;
      frame_q      <= '0;
      tmo_q        <= '0;
      ovr_q        <= '0;
      fault_q      <= 1'b0;
      imu_start_q  <= 1'b0;
      phys_start_q <= 1'b0;
      led_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wait_q       <= wait_d;
      pending_q    <= pending_d;
      phys_data_q  <= phys_data_d;
      frame_q      <= frame_d;
      tmo_q        <= tmo_d;
      ovr_q        <= ovr_d;
      fault_q      <= fault_d;
      imu_start_q  <= imu_start_d;
      phys_start_q <= phys_start_d;
      led_start_q  <= led_start_d;
      busy_q       <= busy_d;
    end
  end

  assign imu_start     = imu_start_q;
  assign phys_start    = phys_start_q;
  assign led_start     = led_start_q;
  assign phys_data     = phys_data_q;
  assign busy          = busy_q;
  assign frame_count   = frame_q;
  assign timeout_count = tmo_q;
  assign overrun_count = ovr_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized scoreboard bench for frame_scheduler: a frame-level model predicts each
// start strobe (stage, cycle, snapshot, counters); a second instance covers overruns.
module tb_frame_scheduler;

  localparam int DW = 96;
  localparam int FC = 100;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset, imu_done, phys_done, led_done;
  logic [DW-1:0] imu_data, phys_data;
  logic          imu_start, phys_start, led_start, busy, fault;
  logic [15:0]   frame_count;
  logic [7:0]    timeout_count, overrun_count;

  logic          o_reset, o_imu_done, o_phys_done, o_led_done;
  logic [DW-1:0] o_imu_data, o_phys_data;
  logic          o_imu_start, o_phys_start, o_led_start, o_busy, o_fault;
  logic [15:0]   o_frame_count;
  logic [7:0]    o_timeout_count, o_overrun_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int o_cyc = 0;
  bit o_fin = 1'b0;

  typedef struct {
    int          stage;
    int          at;
    logic [DW-1:0] pdata;
    int          tcnt;
    int          fcnt;
  } exp_t;
  exp_t exp_q[$];
  int   o_starts[$];

  logic [DW-1:0] m_pdata;
  int m_tcnt, m_fcnt, m_next;

  always #5 clk = ~clk;

  frame_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .imu_start(imu_start), .imu_done(imu_done), .imu_data(imu_data),
    .phys_start(phys_start), .phys_done(phys_done), .phys_data(phys_data),
    .led_start(led_start), .led_done(led_done), .busy(busy), .frame_count(frame_count),
    .timeout_count(timeout_count), .overrun_count(overrun_count), .fault(fault)
  );

  frame_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(200), .DATA_W(DW)) dut_ovr (
    .clk(clk), .reset(o_reset), .imu_start(o_imu_start), .imu_done(o_imu_done), .imu_data(o_imu_data),
    .phys_start(o_phys_start), .phys_done(o_phys_done), .phys_data(o_phys_data),
    .led_start(o_led_start), .led_done(o_led_done), .busy(o_busy), .frame_count(o_frame_count),
    .timeout_count(o_timeout_count), .overrun_count(o_overrun_count), .fault(o_fault)
  );

  // Cycle index since the last cycle with reset asserted (0 = first cycle after reset).
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
    if (o_reset) o_cyc <= 0;
    else         o_cyc <= o_cyc + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_imu_start"}, imu_start, 0);
    chk({tag, "_phys_start"}, phys_start, 0);
    chk({tag, "_led_start"}, led_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_phys_data"}, phys_data, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_timeout_count"}, timeout_count, 0);
    chk({tag, "_overrun_count"}, overrun_count, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  // Scoreboard monitor: every start strobe pops one predicted event.
  always @(negedge clk) begin : mon
    exp_t e;
    int n, stg;
    if (!reset) begin
      n = int'(imu_start) + int'(phys_start) + int'(led_start);
      if (n > 1) chk("one_start_per_cycle", n, 1);
      else if (n == 1) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          stg = imu_start ? 0 : (phys_start ? 1 : 2);
          chk("start_stage", stg, e.stage);
          chk("start_cycle", cyc, e.at);
          chk("phys_data", phys_data, e.pdata);
          chk("timeout_count", timeout_count, e.tcnt);
          chk("fault", fault, (e.tcnt > 0));
          chk("frame_count", frame_count, e.fcnt);
          chk("overrun_count", overrun_count, 0);
          chk("busy", busy, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_imu_start) o_starts.push_back(o_cyc);
  end

  task automatic wait_cyc(input int n);
    if (cyc > n) chk("schedule", cyc, n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_exp(input int stage, input int at);
    exp_t e;
    e.stage = stage; e.at = at; e.pdata = m_pdata; e.tcnt = m_tcnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);
  endtask

  function automatic int pick(input int mode, input int stage);
    int r;
    case (mode)
      1, 4:    return 3;
      2:       return TO + 1;
      3:       return (stage == 0) ? TO + 1 : 3;
      default: begin
        r = $urandom_range(0, 9);
        if (r < 2)      return TO;
        else if (r < 4) return TO + 1;
        else            return $urandom_range(1, TO - 1);
      end
    endcase
  endfunction

  function automatic int lim(input int d);
    return (d < TO) ? d : TO;
  endfunction

  task automatic note_delay(input int d);
    if (d > TO) m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
  endtask

  // Drive the done for one stage d cycles after its start (never, if d exceeds TO).
  task automatic serve(input int stage, input int t, input int d, input logic [DW-1:0] dat);
    for (int c = t + 1; c <= t + lim(d); c++) begin
      wait_cyc(c);
      imu_data  = (stage == 0 && c == t + d) ? dat : {$urandom, $urandom, $urandom};
      imu_done  = (stage == 0 && c == t + d);
      phys_done = (stage == 1 && c == t + d);
      led_done  = (stage == 2 && c == t + d);
      if (stage == 1 && c == t + 1 && d > 1) imu_done = 1'b1;
    end
    wait_cyc(t + lim(d) + 1);
    imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
  endtask

  // mode: 0 random, 1 nominal, 2 all timeouts, 3 IMU timeout, 4 reset in PHYS_WAIT
  task automatic run_frame(input int mode);
    int t, t2, t3, d, e;
    logic [DW-1:0] dat;
    t = m_next;
    push_exp(0, t);
    if (cyc < t - 2) begin
      wait_cyc(t - 2);
      imu_data = {$urandom, $urandom, $urandom};
      imu_done = 1'b1; phys_done = 1'b1; led_done = 1'b1;
      wait_cyc(t - 1);
      imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0;
    end
    wait_cyc(t);
    d = pick(mode, 0);
    dat = {$urandom, $urandom, $urandom};
    if (d <= TO) m_pdata = dat;
    note_delay(d);
    t2 = t + lim(d) + 1;
    push_exp(1, t2);
    serve(0, t, d, dat);
    if (mode == 4) begin
      wait_cyc(t2 + 2);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("mid_reset");
      reset = 1'b0;
      wait_cyc(1);
      phys_done = 1'b1; imu_done = 1'b1;
      wait_cyc(2);
      phys_done = 1'b0; imu_done = 1'b0;
      wait_cyc(4);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_frame_count", frame_count, 0);
      chk("post_reset_phys_data", phys_data, 0);
      chk("post_reset_queue_empty", exp_q.size(), 0);
      m_pdata = '0; m_tcnt = 0; m_fcnt = 0; m_next = FC;
      return;
    end
    d = pick(mode, 1);
    note_delay(d);
    t3 = t2 + lim(d) + 1;
    push_exp(2, t3);
    serve(1, t2, d, '0);
    d = pick(mode, 2);
    note_delay(d);
    e = t3 + lim(d);
    m_fcnt++;
    m_next = ((e + 2 + FC - 1) / FC) * FC;
    serve(2, t3, d, '0);
  endtask

  initial begin : main
    int k;
    reset = 1'b1; imu_done = 1'b0; phys_done = 1'b0; led_done = 1'b0; imu_data = '0;
    m_pdata = '0; m_tcnt = 0; m_fcnt = 0; m_next = FC;
    repeat (3) @(negedge clk);
    chk_zero("por");
    reset = 1'b0;
    run_frame(1);
    run_frame(3);
    repeat (30) run_frame(0);
    repeat (100) run_frame(2);
    run_frame(4);
    run_frame(1);
    run_frame(1);
    chk("final_frame_count", frame_count, m_fcnt);
    chk("final_queue_empty", exp_q.size(), 0);
    reset = 1'b1;
    k = 0;
    while (!o_fin && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("overrun_phase_done", o_fin, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic o_at(input int n);
    while (o_cyc < n) @(negedge clk);
  endtask

  task automatic o_pulse(input int which, input int n, input logic [DW-1:0] dat);
    o_at(n);
    o_imu_done  = (which == 0);
    o_phys_done = (which == 1);
    o_led_done  = (which == 2);
    if (which == 0) o_imu_data = dat;
    o_at(n + 1);
    o_imu_done = 1'b0; o_phys_done = 1'b0; o_led_done = 1'b0;
  endtask

  task automatic o_check(input string tag, input int s0, input int s1, input int s2,
                         input int ovr, input int frames, input logic [DW-1:0] pd);
    int want[3];
    want[0] = s0; want[1] = s1; want[2] = s2;
    chk({tag, "_start_count"}, o_starts.size(), 3);
    for (int i = 0; i < 3; i++)
      chk({tag, "_imu_start_cycle"}, (i < o_starts.size()) ? o_starts[i] : -1, want[i]);
    chk({tag, "_overrun_count"}, o_overrun_count, ovr);
    chk({tag, "_frame_count"}, o_frame_count, frames);
    chk({tag, "_timeout_count"}, o_timeout_count, 0);
    chk({tag, "_fault"}, o_fault, 0);
    chk({tag, "_phys_data"}, o_phys_data, pd);
  endtask

  initial begin : ovr
    logic [DW-1:0] a1, a2;
    o_reset = 1'b1; o_imu_done = 1'b0; o_phys_done = 1'b0; o_led_done = 1'b0; o_imu_data = '0;
    a1 = {$urandom, $urandom, $urandom};
    a2 = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    o_starts.delete();
    o_reset = 1'b0;
    // One missed tick: LED done 150 cycles late, pending frame starts right after IDLE.
    o_pulse(0, 103, a1); o_pulse(1, 107, '0); o_pulse(2, 258, '0);
    o_pulse(0, 263, a2); o_pulse(1, 267, '0); o_pulse(2, 271, '0);
    o_at(305);
    o_check("ovr1", 100, 260, 300, 1, 2, a2);
    o_reset = 1'b1;
    repeat (2) @(negedge clk);
    o_starts.delete();
    o_reset = 1'b0;
    // Three missed ticks collapse into a single extra frame.
    o_pulse(0, 103, a1); o_pulse(1, 294, '0); o_pulse(2, 485, '0);
    o_pulse(0, 490, a2); o_pulse(1, 494, '0); o_pulse(2, 498, '0);
    o_at(505);
    o_check("ovr3", 100, 487, 500, 3, 2, a2);
    o_reset = 1'b1;
    o_fin = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors %0d of %0d checks)", errors, checks);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameters SHALL be: FRAME_CYCLES, default 833333, clocks per frame period; TIMEOUT_CYCLES, default 65535, max wait per stage; DATA_W, default 96, IMU record width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- imu_start  out  1  one-cycle IMU read request.
- imu_done  in  1  IMU record valid on imu_data.
- imu_data  in  DATA_W  IMU record.
- phys_start  out  1  one-cycle physics-step request.
- phys_done  in  1  physics step complete.
- phys_data  out  DATA_W  coherent IMU snapshot for physics.
- led_start  out  1  one-cycle LED refresh request.
- led_done  in  1  LED frame shifted out.
- busy  out  1  high when not IDLE.
- frame_count  out  16  completed frames, wraps.
- timeout_count  out  8  stage timeouts, saturating.
- overrun_count  out  8  frame ticks hit while busy, saturating.
- fault  out  1  sticky, set on any timeout.

Function
REQ-003 Frame timer SHALL count 0..FRAME_CYCLES-1, wrap to 0, and assert an internal tick on the cycle the count equals FRAME_CYCLES-1.
REQ-004 The FSM SHALL have states IDLE, IMU_REQ, IMU_WAIT, PHYS_REQ, PHYS_WAIT, LED_REQ, LED_WAIT.
REQ-005 IDLE SHALL go to IMU_REQ on the cycle after a tick or with a pending tick; *_REQ states SHALL last exactly one cycle, drive the matching *_start high, then go to the matching *_WAIT.
REQ-006 *_start SHALL be high only in the matching *_REQ state; at most one start is high per cycle.
REQ-007 *_done SHALL be sampled only in the matching *_WAIT state; done in any other state SHALL be ignored.
REQ-008 IMU_WAIT with imu_done SHALL load imu_data into phys_data on that edge and go to PHYS_REQ; phys_data SHALL change at no other time.
REQ-009 PHYS_WAIT with phys_done SHALL go to LED_REQ; LED_WAIT with led_done SHALL go to IDLE and increment frame_count modulo 2^16.
REQ-010 A wait counter SHALL clear on entry to each *_WAIT; if TIMEOUT_CYCLES cycles pass without done, the FSM SHALL leave as if done arrived, except an IMU timeout SHALL keep phys_data unchanged.
REQ-011 Each timeout SHALL increment timeout_count (saturate at 255) and set fault; fault clears only on reset.
REQ-012 Done and timeout in the same cycle SHALL count as done, with no timeout recorded.
REQ-013 A tick while busy SHALL set a one-deep pending flag and increment overrun_count (saturate at 255); further ticks while pending SHALL only increment overrun_count.
REQ-014 Pending SHALL clear when IDLE goes to IMU_REQ; a tick arriving on that same cycle SHALL set pending again.
REQ-015 A led_done completing a frame on a cycle with pending set SHALL go to IDLE, then to IMU_REQ on the next cycle.
REQ-016 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-017 With reset high at a clk edge, the following SHALL all be zero on the next cycle: state=IDLE, frame timer, wait counter, pending flag, phys_data, all counters, fault, all *_start, busy.
REQ-018 Reset mid-stage SHALL abandon the stage without completing the handshake; later done pulses in IDLE SHALL be ignored.

Structure
REQ-019 The FSM state enum and saturating-counter width constants SHALL be in a shared package, frame_pkg.
REQ-020 The frame timer SHALL be one sub-module, frame_timer (params FRAME_CYCLES; ports clk, reset, tick); all else SHALL be inline.

Verification (FRAME_CYCLES=100, TIMEOUT_CYCLES=20)
REQ-021 Nominal: each done returned 3 cycles after its start -> start order imu, phys, led; phys_data equals imu_data sampled at imu_done; frame_count=1 after first frame; fault=0.
REQ-022 IMU timeout: imu_done never asserted -> phys_start 21 cycles after imu_start; phys_data keeps prior value; timeout_count=1; fault=1.
REQ-023 Overrun: led_done delayed 150 cycles after led_start -> overrun_count=1; imu_start one cycle after return to IDLE; 3 missed ticks -> overrun_count=3, only one extra frame starts.
REQ-024 Stray and simultaneous done: imu_done pulsed in IDLE and PHYS_WAIT -> no state effect. phys_done on the 20th wait cycle -> no timeout recorded.
REQ-025 Saturation and reset: force 300 timeouts -> timeout_count holds 255. Assert reset during PHYS_WAIT -> all outputs 0 the next cycle; a phys_done afterward is ignored.
